// File: rtl/exe_pkg.sv
// Shared encodings for the multicycle EXE-stage controller: instruction fields,
// ALU operation codes, operand/PC select encodings and the controller state set.
package exe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_EXECUTE   = 4'd7,
        ST_R_WB      = 4'd8,
        ST_ADDI_EX   = 4'd9,
        ST_ADDI_WB   = 4'd10,
        ST_BRANCH    = 4'd11,
        ST_JUMP      = 4'd12
    } state_t;

    function automatic logic opcode_known(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J: opcode_known = 1'b1;
            default:                                       opcode_known = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps an R-type funct field to the ALU operation; valid is low for any
// funct the ALU does not support, in which case the operation reads as AND.
module alu_decoder
    import exe_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       valid
);

    // funct lookup
    always_comb begin
        alu_op = ALU_AND;
        valid  = 1'b0;
        case (funct)
            FN_ADD: begin alu_op = ALU_ADD; valid = 1'b1; end
            FN_SUB: begin alu_op = ALU_SUB; valid = 1'b1; end
            FN_AND: begin alu_op = ALU_AND; valid = 1'b1; end
            FN_OR:  begin alu_op = ALU_OR;  valid = 1'b1; end
            FN_SLT: begin alu_op = ALU_SLT; valid = 1'b1; end
            default: begin alu_op = ALU_AND; valid = 1'b0; end
        endcase
    end

endmodule

// File: rtl/exe_control.sv
// Multicycle fetch/decode/execute/memory/writeback controller driving the EXE
// stage ALU. Outputs decode combinationally from the state register.
module exe_control
    import exe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             Zero_signal,
    input  logic             mem_ready,
    output logic [3:0]       ALU_operation,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic             pc_we,
    output logic             ir_we,
    output logic             i_or_d,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instr_count
);

    state_t     state_r;
    state_t     next_state_s;
    state_t     end_next_s;
    logic       end_s;
    logic [3:0] dec_op_s;
    logic       dec_valid_s;

    alu_decoder u_alu_decoder (
        .funct  (funct),
        .alu_op (dec_op_s),
        .valid  (dec_valid_s)
    );

    // next-state selection; end_s marks the retirement of an instruction
    always_comb begin
        next_state_s = state_r;
        end_s        = 1'b0;
        end_next_s   = run ? ST_FETCH : ST_IDLE;
        case (state_r)
            ST_IDLE:   next_state_s = run ? ST_FETCH : ST_IDLE;
            ST_FETCH:  next_state_s = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:      next_state_s = ST_EXECUTE;
                    OP_LW, OP_SW:  next_state_s = ST_MEM_ADDR;
                    OP_ADDI:       next_state_s = ST_ADDI_EX;
                    OP_BEQ:        next_state_s = ST_BRANCH;
                    OP_J:          next_state_s = ST_JUMP;
                    default: begin next_state_s = end_next_s; end_s = 1'b1; end
                endcase
            end
            ST_MEM_ADDR: begin
                case (opcode)
                    OP_LW:   next_state_s = ST_MEM_READ;
                    OP_SW:   next_state_s = ST_MEM_WRITE;
                    default: begin next_state_s = end_next_s; end_s = 1'b1; end
                endcase
            end
            ST_MEM_READ: next_state_s = mem_ready ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WRITE: begin
                next_state_s = mem_ready ? end_next_s : ST_MEM_WRITE;
                end_s        = mem_ready;
            end
            ST_EXECUTE: begin
                next_state_s = dec_valid_s ? ST_R_WB : end_next_s;
                end_s        = ~dec_valid_s;
            end
            ST_ADDI_EX: next_state_s = ST_ADDI_WB;
            ST_MEM_WB, ST_R_WB, ST_ADDI_WB, ST_BRANCH, ST_JUMP: begin
                next_state_s = end_next_s;
                end_s        = 1'b1;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // retired-instruction counter, wraps naturally at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= {CNT_W{1'b0}};
        end else if (end_s) begin
            instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instr_count <= instr_count;
        end
    end

    // Moore output decode; FETCH strobes follow mem_ready, BRANCH pc_we follows Zero_signal
    always_comb begin
        ALU_operation = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        pc_src        = PC_SRC_ALU;
        pc_we         = 1'b0;
        ir_we         = 1'b0;
        i_or_d        = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        reg_we        = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_instr = 1'b0;
        case (state_r)
            ST_IDLE: ALU_operation = ALU_AND;
            ST_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b     = SRC_B_IMM_SH;
                illegal_instr = ~opcode_known(opcode);
            end
            ST_MEM_ADDR, ST_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            ST_MEM_READ: begin
                mem_rd = 1'b1;
                i_or_d = 1'b1;
            end
            ST_MEM_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_wr = 1'b1;
                i_or_d = 1'b1;
            end
            ST_EXECUTE: begin
                alu_src_a     = 1'b1;
                ALU_operation = dec_op_s;
                illegal_instr = ~dec_valid_s;
            end
            ST_R_WB: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
            end
            ST_ADDI_WB: reg_we = 1'b1;
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                ALU_operation = ALU_SUB;
                pc_src        = PC_SRC_ALUOUT;
                pc_we         = Zero_signal;
            end
            ST_JUMP: begin
                pc_src = PC_SRC_JUMP;
                pc_we  = 1'b1;
            end
            default: ALU_operation = ALU_AND;
        endcase
    end

endmodule

// File: tb/tb_exe_control.sv
// Table-driven check of exe_control plus hand-written reset-abort and
// counter-wrap sequences (the wrap uses a narrow-counter second instance).
module tb_exe_control;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero_sig;
    logic       mem_ready;

    logic [3:0]  alu_op, alu_op_w;
    logic        src_a, src_a_w;
    logic [1:0]  src_b, src_b_w, psrc, psrc_w;
    logic        pc_we, ir_we, i_or_d, mem_rd, mem_wr, reg_we, reg_dst, m2r, ill;
    logic        pc_we_w, ir_we_w, i_or_d_w, mem_rd_w, mem_wr_w, reg_we_w, reg_dst_w, m2r_w, ill_w;
    logic [15:0] cnt_main;
    logic [3:0]  cnt_w;
    logic [17:0] obs, obs_w;

    int checks   = 0;
    int failures = 0;

    exe_control dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct(funct),
        .Zero_signal(zero_sig), .mem_ready(mem_ready), .ALU_operation(alu_op),
        .alu_src_a(src_a), .alu_src_b(src_b), .pc_src(psrc), .pc_we(pc_we),
        .ir_we(ir_we), .i_or_d(i_or_d), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(m2r),
        .illegal_instr(ill), .instr_count(cnt_main)
    );

    exe_control #(.CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct(funct),
        .Zero_signal(zero_sig), .mem_ready(mem_ready), .ALU_operation(alu_op_w),
        .alu_src_a(src_a_w), .alu_src_b(src_b_w), .pc_src(psrc_w), .pc_we(pc_we_w),
        .ir_we(ir_we_w), .i_or_d(i_or_d_w), .mem_rd(mem_rd_w), .mem_wr(mem_wr_w),
        .reg_we(reg_we_w), .reg_dst(reg_dst_w), .mem_to_reg(m2r_w),
        .illegal_instr(ill_w), .instr_count(cnt_w)
    );

    assign obs   = {alu_op, src_a, src_b, psrc, pc_we, ir_we, i_or_d, mem_rd, mem_wr,
                    reg_we, reg_dst, m2r, ill};
    assign obs_w = {alu_op_w, src_a_w, src_b_w, psrc_w, pc_we_w, ir_we_w, i_or_d_w, mem_rd_w,
                    mem_wr_w, reg_we_w, reg_dst_w, m2r_w, ill_w};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {alu_op, src_a, src_b, pc_src, pc_we, ir_we, i_or_d, mem_rd, mem_wr, reg_we, reg_dst, mem_to_reg, illegal}
    localparam logic [17:0] E_IDLE    = 18'h0;
    localparam logic [17:0] E_FETCH   = {4'b0010, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_FETCH_R = {4'b0010, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_DECODE  = {4'b0010, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_DEC_ILL = {4'b0010, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [17:0] E_EXE_SUB = {4'b0110, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_EXE_ILL = {4'b0000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [17:0] E_RWB     = {4'b0010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic [17:0] E_MADDR   = {4'b0010, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_MREAD   = {4'b0010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_MWB     = {4'b0010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [17:0] E_MWRITE  = {4'b0010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_BR_Z    = {4'b0110, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_BR_NZ   = {4'b0110, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_JUMP    = {4'b0010, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    typedef struct {
        logic        run;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zero;
        logic        rdy;
        logic [17:0] exp;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 38;
    vec_t vecs [NV];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, act, exp);
        end
    endtask

    initial begin
        // each row: inputs applied this cycle, outputs expected this cycle
        vecs[0]  = '{1'b0, 6'h00, 6'h00, 1'b0, 1'b0, E_IDLE,    16'd0};
        vecs[1]  = '{1'b1, 6'h00, 6'h22, 1'b0, 1'b0, E_IDLE,    16'd0};
        vecs[2]  = '{1'b1, 6'h00, 6'h22, 1'b0, 1'b1, E_FETCH_R, 16'd0};
        vecs[3]  = '{1'b1, 6'h00, 6'h22, 1'b0, 1'b1, E_DECODE,  16'd0};
        vecs[4]  = '{1'b1, 6'h00, 6'h22, 1'b0, 1'b1, E_EXE_SUB, 16'd0};
        vecs[5]  = '{1'b1, 6'h00, 6'h22, 1'b0, 1'b1, E_RWB,     16'd0};
        vecs[6]  = '{1'b1, 6'h23, 6'h00, 1'b0, 1'b0, E_FETCH,   16'd1};
        vecs[7]  = '{1'b1, 6'h23, 6'h00, 1'b0, 1'b1, E_FETCH_R, 16'd1};
        vecs[8]  = '{1'b1, 6'h23, 6'h00, 1'b0, 1'b1, E_DECODE,  16'd1};
        vecs[9]  = '{1'b1, 6'h23, 6'h00, 1'b0, 1'b1, E_MADDR,   16'd1};
        vecs[10] = '{1'b1, 6'h23, 6'h00, 1'b0, 1'b0, E_MREAD,   16'd1};
        vecs[11] = '{1'b1, 6'h23, 6'h00, 1'b0, 1'b0, E_MREAD,   16'd1};
        vecs[12] = '{1'b1, 6'h23, 6'h00, 1'b0, 1'b1, E_MREAD,   16'd1};
        vecs[13] = '{1'b1, 6'h23, 6'h00, 1'b0, 1'b1, E_MWB,     16'd1};
        vecs[14] = '{1'b1, 6'h04, 6'h00, 1'b1, 1'b1, E_FETCH_R, 16'd2};
        vecs[15] = '{1'b1, 6'h04, 6'h00, 1'b1, 1'b1, E_DECODE,  16'd2};
        vecs[16] = '{1'b1, 6'h04, 6'h00, 1'b1, 1'b1, E_BR_Z,    16'd2};
        vecs[17] = '{1'b1, 6'h04, 6'h00, 1'b0, 1'b1, E_FETCH_R, 16'd3};
        vecs[18] = '{1'b1, 6'h04, 6'h00, 1'b0, 1'b1, E_DECODE,  16'd3};
        vecs[19] = '{1'b1, 6'h04, 6'h00, 1'b0, 1'b1, E_BR_NZ,   16'd3};
        vecs[20] = '{1'b1, 6'h3F, 6'h00, 1'b0, 1'b1, E_FETCH_R, 16'd4};
        vecs[21] = '{1'b1, 6'h3F, 6'h00, 1'b0, 1'b1, E_DEC_ILL, 16'd4};
        vecs[22] = '{1'b1, 6'h00, 6'h03, 1'b0, 1'b1, E_FETCH_R, 16'd5};
        vecs[23] = '{1'b1, 6'h00, 6'h03, 1'b0, 1'b1, E_DECODE,  16'd5};
        vecs[24] = '{1'b1, 6'h00, 6'h03, 1'b0, 1'b1, E_EXE_ILL, 16'd5};
        vecs[25] = '{1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, E_FETCH,   16'd6};
        vecs[26] = '{1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, E_FETCH_R, 16'd6};
        vecs[27] = '{1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, E_DECODE,  16'd6};
        vecs[28] = '{1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, E_MADDR,   16'd6};
        vecs[29] = '{1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, E_MWRITE,  16'd6};
        vecs[30] = '{1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, E_MWRITE,  16'd6};
        vecs[31] = '{1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, E_IDLE,    16'd7};
        vecs[32] = '{1'b0, 6'h02, 6'h00, 1'b0, 1'b1, E_IDLE,    16'd7};
        vecs[33] = '{1'b1, 6'h02, 6'h00, 1'b0, 1'b0, E_IDLE,    16'd7};
        vecs[34] = '{1'b1, 6'h02, 6'h00, 1'b0, 1'b1, E_FETCH_R, 16'd7};
        vecs[35] = '{1'b1, 6'h02, 6'h00, 1'b0, 1'b1, E_DECODE,  16'd7};
        vecs[36] = '{1'b1, 6'h02, 6'h00, 1'b0, 1'b1, E_JUMP,    16'd7};
        vecs[37] = '{1'b0, 6'h02, 6'h00, 1'b0, 1'b0, E_FETCH,   16'd8};

        rst_n = 1'b0; run = 1'b0; opcode = 6'h00; funct = 6'h00; zero_sig = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", 0, 32'(obs), 32'(E_IDLE));
        chk("reset_count", 0, 32'(cnt_main), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            run = vecs[i].run; opcode = vecs[i].op; funct = vecs[i].fn;
            zero_sig = vecs[i].zero; mem_ready = vecs[i].rdy;
            @(negedge clk);
            chk("outs", i, 32'(obs), 32'(vecs[i].exp));
            chk("outs_w", i, 32'(obs_w), 32'(vecs[i].exp));
            chk("count", i, 32'(cnt_main), 32'(vecs[i].cnt));
            chk("count_w", i, 32'(cnt_w), 32'(vecs[i].cnt[3:0]));
        end

        // lw reaches MEM_READ, then reset is asserted mid-wait
        @(posedge clk); #1;
        run = 1'b1; opcode = 6'h23; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("abort_pre_mread", 0, 32'(obs), 32'(E_MREAD));
        #1 rst_n = 1'b0;
        #1;
        chk("abort_outs", 0, 32'(obs), 32'(E_IDLE));
        chk("abort_count", 0, 32'(cnt_main), 32'd0);
        chk("abort_count_w", 0, 32'(cnt_w), 32'd0);
        opcode = 6'h3F; mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // 15 illegal instructions at two cycles each bring the narrow counter to 0xF
        repeat (31) @(posedge clk);
        #1;
        chk("wrap_pre_count_w", 0, 32'(cnt_w), 32'hF);
        chk("wrap_pre_count", 0, 32'(cnt_main), 32'd15);
        chk("wrap_pre_outs", 0, 32'(obs), 32'(E_FETCH_R));
        opcode = 6'h2B; run = 1'b0;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        chk("wrap_sw_wait", 0, 32'(obs), 32'(E_MWRITE));
        chk("wrap_sw_count_w", 0, 32'(cnt_w), 32'hF);
        @(posedge clk); #1;
        chk("wrap_sw_hold", 0, 32'(obs), 32'(E_MWRITE));
        mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("wrap_count_w", 0, 32'(cnt_w), 32'h0);
        chk("wrap_count", 0, 32'(cnt_main), 32'd16);
        chk("wrap_idle_outs", 0, 32'(obs), 32'(E_IDLE));
        chk("wrap_idle_outs_w", 0, 32'(obs_w), 32'(E_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
